// File: rtl/shift_seq_pkg.sv
// Shared types and constants for the shift-register control sequencer.
package shift_seq_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PREP  = 2'd1,
      ST_SHIFT = 2'd2,
      ST_DONE  = 2'd3
   } shift_seq_state_t;

   localparam logic MODE_SER = 1'b0;
   localparam logic MODE_DES = 1'b1;

   localparam logic DIR_L = 1'b0;
   localparam logic DIR_R = 1'b1;

endpackage

// File: rtl/shift_seq_cnt.sv
// Loadable down-counter holding the number of shifts still to issue.
module shift_seq_cnt #(
   parameter int N  = 16,
   parameter int CW = $clog2(N + 1)
) (
   input  logic          clk,
   input  logic          clr,
   input  logic          load,
   input  logic [CW-1:0] load_val,
   input  logic          dec,
   output logic [CW-1:0] cnt,
   output logic          is_one
);

   logic [CW-1:0] cnt_q, cnt_d;
   logic [CW-1:0] load_sat;

   always_comb begin
      // Requests longer than the register are clipped to its width.
      load_sat = (load_val > CW'(N)) ? CW'(N) : load_val;
      cnt_d    = cnt_q;
      if (clr)
         cnt_d = '0;
      else if (load)
         cnt_d = load_sat;
      else if (dec && (cnt_q != '0))
         cnt_d = cnt_q - CW'(1);
   end

   always_ff @(posedge clk) begin
      cnt_q <= cnt_d;
   end

   assign cnt    = cnt_q;
   assign is_one = (cnt_q == CW'(1));

endmodule

// File: rtl/shift_sequencer.sv
// Drives load/clear/shift controls of an N-bit shift register for a programmed shift count.
module shift_sequencer
   import shift_seq_pkg::*;
#(
   parameter int N  = 16,
   parameter int CW = $clog2(N + 1)
) (
   input  logic          clk,
   input  logic          clear,
   input  logic          start,
   input  logic          mode,
   input  logic          dir,
   input  logic [CW-1:0] count,
   input  logic          fill,
   input  logic          ser_in,
   input  logic          ser_valid,
   input  logic          abort,
   output logic          reg_load,
   output logic          reg_clear,
   output logic          reg_shiftL,
   output logic          reg_shiftR,
   output logic          reg_shiftin,
   output logic          busy,
   output logic          done,
   output logic [CW-1:0] bits_left
);

   shift_seq_state_t state_q, state_d;
   logic             mode_q, mode_d;
   logic             dir_q, dir_d;
   logic             fill_q, fill_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic             shift_issue;
   logic             cnt_load;
   logic             cnt_clr;
   logic             cnt_is_one;
   logic [CW-1:0]    cnt_val;

   shift_seq_cnt #(
      .N  (N),
      .CW (CW)
   ) u_cnt (
      .clk      (clk),
      .clr      (cnt_clr),
      .load     (cnt_load),
      .load_val (count),
      .dec      (shift_issue),
      .cnt      (cnt_val),
      .is_one   (cnt_is_one)
   );

   always_ff @(posedge clk) begin
      if (clear) begin
         state_q <= ST_IDLE;
         mode_q  <= MODE_SER;
         dir_q   <= DIR_L;
         fill_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         dir_q   <= dir_d;
         fill_q  <= fill_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      mode_d   = mode_q;
      dir_d    = dir_q;
      fill_d   = fill_q;
      cnt_load = 1'b0;
      cnt_clr  = clear;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d  = ST_PREP;
               mode_d   = mode;
               dir_d    = dir;
               fill_d   = fill;
               cnt_load = 1'b1;
            end
         end
         ST_PREP: begin
            if (abort) begin
               state_d = ST_IDLE;
               cnt_clr = 1'b1;
            end else if (cnt_val != '0) begin
               state_d = ST_SHIFT;
            end else begin
               state_d = ST_DONE;
            end
         end
         ST_SHIFT: begin
            if (abort) begin
               state_d = ST_IDLE;
               cnt_clr = 1'b1;
            end else if (shift_issue && cnt_is_one) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
      // Status flags are registered copies of the next-state decode.
      busy_d = (state_d != ST_IDLE);
      done_d = (state_d == ST_DONE);
   end

   always_comb begin
      reg_load    = 1'b0;
      reg_clear   = 1'b0;
      reg_shiftL  = 1'b0;
      reg_shiftR  = 1'b0;
      reg_shiftin = 1'b0;
      case (state_q)
         ST_PREP: begin
            if (mode_q == MODE_SER)
               reg_load = 1'b1;
            else
               reg_clear = 1'b1;
         end
         ST_SHIFT: begin
            if (mode_q == MODE_SER) begin
               if (dir_q == DIR_L) begin
                  reg_shiftL  = 1'b1;
                  reg_shiftin = fill_q;
               end else begin
                  reg_shiftR  = 1'b1;
               end
            end else begin
               reg_shiftL  = ser_valid;
               reg_shiftin = ser_in;
            end
         end
         default: ;
      endcase
      shift_issue = reg_shiftL | reg_shiftR;
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign bits_left = cnt_val;

endmodule

// File: tb/tb_shift_sequencer.sv
// Scoreboard bench for shift_sequencer with a behavioural 16-bit shift register on the controls.
module tb_shift_sequencer;

   localparam int N  = 16;
   localparam int CW = $clog2(N + 1);

   logic          clk = 1'b0;
   logic          clear, start, mode, dir, fill, ser_in, ser_valid, abort;
   logic [CW-1:0] count;
   logic          reg_load, reg_clear, reg_shiftL, reg_shiftR, reg_shiftin;
   logic          busy, done;
   logic [CW-1:0] bits_left;

   logic [N-1:0]  din;
   logic [N-1:0]  sreg;

   logic [11:0]   exp_q[$];
   logic [11:0]   exp_v, obs_v;
   int unsigned   total  = 0;
   int unsigned   passed = 0;

   shift_sequencer #(.N(N)) dut (
      .clk         (clk),
      .clear       (clear),
      .start       (start),
      .mode        (mode),
      .dir         (dir),
      .count       (count),
      .fill        (fill),
      .ser_in      (ser_in),
      .ser_valid   (ser_valid),
      .abort       (abort),
      .reg_load    (reg_load),
      .reg_clear   (reg_clear),
      .reg_shiftL  (reg_shiftL),
      .reg_shiftR  (reg_shiftR),
      .reg_shiftin (reg_shiftin),
      .busy        (busy),
      .done        (done),
      .bits_left   (bits_left)
   );

   always #5 clk = ~clk;

   // Downstream register: right shifts always insert 0.
   always @(posedge clk) begin
      if (reg_clear)       sreg <= '0;
      else if (reg_load)   sreg <= din;
      else if (reg_shiftL) sreg <= {sreg[N-2:0], reg_shiftin};
      else if (reg_shiftR) sreg <= {1'b0, sreg[N-1:1]};
   end

   function automatic logic [11:0] mk(input logic ld, cl, sl, sr, si, bz, dn, input int bl);
      return {ld, cl, sl, sr, si, bz, dn, 5'(bl)};
   endfunction

   // Expected trace of a serialize op: start cycle, PREP, c shifts, DONE, one idle cycle.
   task automatic push_ser0(input int c, input logic d, input logic f);
      exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
      exp_q.push_back(mk(1, 0, 0, 0, 0, 1, 0, c));
      for (int k = 0; k < c; k++)
         exp_q.push_back(mk(0, 0, !d, d, d ? 1'b0 : f, 1, 0, c - k));
      exp_q.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0));
      exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
   endtask

   task automatic drive(input logic st, md, dr, input logic [CW-1:0] cn,
                        input logic fl, si, sv, ab, cl);
      @(negedge clk);
      start = st; mode = md; dir = dr; count = cn; fill = fl;
      ser_in = si; ser_valid = sv; abort = ab; clear = cl;
      #1;
   endtask

   function automatic logic [11:0] observe();
      return {reg_load, reg_clear, reg_shiftL, reg_shiftR, reg_shiftin, busy, done, bits_left};
   endfunction

   task automatic test_reset();
      int n;
      drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
      repeat (3) exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
      n = exp_q.size();
      for (int c = 0; c < n; c++) begin
         drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
         obs_v = observe(); exp_v = exp_q.pop_front(); total++;
         if (obs_v !== exp_v) $display("FAIL reset cycle %0d: got %b required %b", c, obs_v, exp_v);
         else passed++;
      end
   endtask

   task automatic test_ser_left();
      int n;
      din = 16'h00F0;
      push_ser0(4, 0, 1);
      n = exp_q.size();
      for (int c = 0; c < n; c++) begin
         drive(c == 0, 0, 0, 4, 1, 0, 0, 0, 0);
         obs_v = observe(); exp_v = exp_q.pop_front(); total++;
         if (obs_v !== exp_v) $display("FAIL ser_left cycle %0d: got %b required %b", c, obs_v, exp_v);
         else passed++;
      end
      total++;
      if (sreg !== 16'h0F0F) $display("FAIL ser_left_reg: got %h required 0f0f", sreg);
      else passed++;
   endtask

   task automatic test_ser_right();
      int n;
      din = 16'h8000;
      push_ser0(3, 1, 1);
      n = exp_q.size();
      for (int c = 0; c < n; c++) begin
         drive(c == 0, 0, 1, 3, 1, 0, 0, 0, 0);
         obs_v = observe(); exp_v = exp_q.pop_front(); total++;
         if (obs_v !== exp_v) $display("FAIL ser_right cycle %0d: got %b required %b", c, obs_v, exp_v);
         else passed++;
      end
      total++;
      if (sreg !== 16'h1000) $display("FAIL ser_right_reg: got %h required 1000", sreg);
      else passed++;
   endtask

   task automatic test_count_bounds();
      int n;
      din = 16'h1234;
      push_ser0(0, 0, 1);
      n = exp_q.size();
      for (int c = 0; c < n; c++) begin
         drive(c == 0, 0, 0, 0, 1, 0, 0, 0, 0);
         obs_v = observe(); exp_v = exp_q.pop_front(); total++;
         if (obs_v !== exp_v) $display("FAIL count0 cycle %0d: got %b required %b", c, obs_v, exp_v);
         else passed++;
      end
      din = 16'hFFFF;
      push_ser0(16, 0, 0);
      n = exp_q.size();
      for (int c = 0; c < n; c++) begin
         drive(c == 0, 0, 0, 20, 0, 0, 0, 0, 0);
         obs_v = observe(); exp_v = exp_q.pop_front(); total++;
         if (obs_v !== exp_v) $display("FAIL count20 cycle %0d: got %b required %b", c, obs_v, exp_v);
         else passed++;
      end
      total++;
      if (sreg !== 16'h0000) $display("FAIL count20_reg: got %h required 0000", sreg);
      else passed++;
   endtask

   task automatic test_deser();
      logic [7:0] bits;
      int n, off;
      logic sv, si;
      bits = 8'b1011_0010;
      din  = 16'hFFFF;
      exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
      exp_q.push_back(mk(0, 1, 0, 0, 0, 1, 0, 8));
      for (int j = 0; j < 8; j++) begin
         exp_q.push_back(mk(0, 0, 1, 0, bits[7-j], 1, 0, 8 - j));
         if (j < 7) exp_q.push_back(mk(0, 0, 0, 0, 0, 1, 0, 7 - j));
      end
      exp_q.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0));
      exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
      n = exp_q.size();
      for (int c = 0; c < n; c++) begin
         off = c - 2;
         sv  = (off >= 0) && (off % 2 == 0) && (off / 2 < 8);
         si  = sv ? bits[7 - off / 2] : 1'b0;
         drive(c == 0, 1, 1, 8, 1, si, sv, 0, 0);
         obs_v = observe(); exp_v = exp_q.pop_front(); total++;
         if (obs_v !== exp_v) $display("FAIL deser cycle %0d: got %b required %b", c, obs_v, exp_v);
         else passed++;
      end
      total++;
      if (sreg !== 16'h00B2) $display("FAIL deser_reg: got %h required 00b2", sreg);
      else passed++;
   endtask

   task automatic test_abort();
      int n;
      din = 16'h0001;
      exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
      exp_q.push_back(mk(1, 0, 0, 0, 0, 1, 0, 8));
      for (int k = 0; k < 3; k++) exp_q.push_back(mk(0, 0, 1, 0, 1, 1, 0, 8 - k));
      repeat (3) exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
      n = exp_q.size();
      for (int c = 0; c < n; c++) begin
         drive(c == 0 || c == 3, 0, 0, 8, 1, 0, 0, c == 4, 0);
         obs_v = observe(); exp_v = exp_q.pop_front(); total++;
         if (obs_v !== exp_v) $display("FAIL abort cycle %0d: got %b required %b", c, obs_v, exp_v);
         else passed++;
      end
      total++;
      if (sreg !== 16'h000F) $display("FAIL abort_reg: got %h required 000f", sreg);
      else passed++;
   endtask

   task automatic test_clear_mid();
      int n;
      din = 16'hFFFF;
      exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
      exp_q.push_back(mk(1, 0, 0, 0, 0, 1, 0, 10));
      for (int k = 0; k < 6; k++) exp_q.push_back(mk(0, 0, 0, 1, 0, 1, 0, 10 - k));
      repeat (2) exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
      n = exp_q.size();
      for (int c = 0; c < n; c++) begin
         drive(c == 0, 0, 1, 10, 0, 0, 0, 0, c == 7);
         obs_v = observe(); exp_v = exp_q.pop_front(); total++;
         if (obs_v !== exp_v) $display("FAIL clear_mid cycle %0d: got %b required %b", c, obs_v, exp_v);
         else passed++;
      end
      total++;
      if (sreg !== 16'h03FF) $display("FAIL clear_mid_reg: got %h required 03ff", sreg);
      else passed++;
   endtask

   initial begin
      clear = 1'b1; start = 1'b0; mode = 1'b0; dir = 1'b0; count = '0;
      fill = 1'b0; ser_in = 1'b0; ser_valid = 1'b0; abort = 1'b0; din = '0;
      test_reset();
      test_ser_left();
      test_ser_right();
      test_count_bounds();
      test_deser();
      test_abort();
      test_clear_mid();
      test_ser_right();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/shift_sequencer.md
# shift_sequencer

Control stage directly upstream of the team's N-bit parallel-load shift register. It accepts a start command, then drives the register's load/clear/shift/shift-in controls for a programmed number of shift cycles, and reports completion. Two modes: serialize (load a parallel word, then shift it out) and deserialize (clear the register, then shift in bits from a serial source under a valid qualifier).

## Interface
- `N`, 16, width of the controlled shift register; legal range 2..64
- `CW`, `$clog2(N+1)`, width of the shift-count fields
- `clk` input 1, single clock, rising edge
- `clear` input 1, reset: synchronous, active-high
- `start` input 1, command strobe; sampled only in IDLE
- `mode` input 1, 0 = serialize (load then shift), 1 = deserialize (clear then shift in); sampled with `start`
- `dir` input 1, 0 = left, 1 = right; sampled with `start`; ignored in mode 1, which always shifts left
- `count` input CW, number of shifts; sampled with `start`; values > N saturate to N
- `fill` input 1, shift-in value for mode 0 left shifts; sampled with `start`
- `ser_in` input 1, serial data for mode 1
- `ser_valid` input 1, qualifies `ser_in`; mode 1 issues one shift per cycle in which it is high
- `abort` input 1, terminates an operation in progress
- `reg_load`, `reg_clear`, `reg_shiftL`, `reg_shiftR`, `reg_shiftin` output 1 each, controls to the shift register
- `busy` output 1, high whenever state ≠ IDLE
- `done` output 1, one-cycle completion pulse
- `bits_left` output CW, shifts remaining

## Operation
- States: IDLE, PREP, SHIFT, DONE.
- IDLE: all control outputs are 0. If `start` = 1, capture `mode`, `dir`, `fill` and the saturated `count` into `bits_left`, then go to PREP.
- PREP, one cycle: mode 0 asserts `reg_load`; mode 1 asserts `reg_clear`. Next state is SHIFT if `bits_left` > 0, else DONE.
- SHIFT, mode 0: one shift is issued every cycle.
  - Left: `reg_shiftL` = 1 and `reg_shiftin` = captured `fill`.
  - Right: `reg_shiftR` = 1. The register inserts 0; `reg_shiftin` = 0.
- SHIFT, mode 1: `reg_shiftL` = `ser_valid` and `reg_shiftin` = `ser_in`. This is the only combinational input-to-output path.
- Each issued shift decrements `bits_left`. A shift issued with `bits_left` = 1 moves the FSM to DONE.
- DONE, one cycle: `done` = 1 and `busy` = 1. Next state is IDLE.
- At most one control output is high in any cycle. `reg_shiftL` and `reg_shiftR` are never high together.
- `start` outside IDLE is ignored; no queuing.
- `abort` sampled high in PREP or SHIFT:
  - Next state is IDLE, with no `done` pulse and `bits_left` set to 0.
  - The control output of the abort cycle itself is still issued and counted.
- `abort` in IDLE or DONE has no effect.
- Same-edge priority: `clear` > `abort` > normal transition.

## Timing
- Reset (`clear` sampled high): state IDLE, `bits_left` 0, `busy` 0, `done` 0, every `reg_*` output 0, from the following cycle.
  - Outputs in the `clear` cycle itself still reflect the current state.
  - A mid-operation reset does not clear the downstream register.
- Cycle numbering: `start` is sampled at the end of cycle 0.
  - Cycle 1: PREP.
  - Mode 0: shifts in cycles 2..C+1, `done` in cycle C+2, IDLE in cycle C+3. The earliest next `start` is sampled in cycle C+3.
  - Mode 1: `done` falls in the cycle after the C-th valid-qualified shift.
- `count` = 0: `done` in cycle 2.
- State, `bits_left`, `busy` and `done` are registered. Control outputs are decoded from the registered state and captured operands; the mode-1 `ser_*` path is the only exception.

## Structure
- Package `shift_seq_pkg` holds:
  - the state enum typedef `shift_seq_state_t`;
  - the mode constants `MODE_SER` = 0 and `MODE_DES` = 1;
  - the direction constants `DIR_L` = 0 and `DIR_R` = 1.
- One sub-module, `shift_seq_cnt`: a loadable CW-bit down-counter.
  - Ports: load, load value with saturation to N, decrement enable, synchronous clear.
  - Outputs: count, and `is_one` for the terminal-shift decision.
- The FSM and output decode stay in `shift_sequencer`.

## Test plan
All scenarios use N = 16, with a behavioural shift-register model attached to the `reg_*` outputs.
- Mode 0, left, count 4, fill 1, Din 0x00F0 -> `reg_load` in cycle 1, `reg_shiftL` in cycles 2–5, `done` in cycle 6, register = 0x0F0F.
- Mode 0, right, count 3, Din 0x8000 -> 3 `reg_shiftR` pulses, register = 0x1000, `bits_left` counting 3, 2, 1, 0.
- Mode 1, count 8, `ser_valid` every other cycle, bits 1,0,1,1,0,0,1,0 -> `reg_clear` in cycle 1, 8 shifts, register = 0x00B2, `done` one cycle after the 8th valid.
- Count 0 -> `done` in cycle 2 with no shifts. Count 20 -> exactly 16 shifts, initial `bits_left` = 16.
- `abort` high during the 3rd shift cycle -> exactly 3 shifts, no `done`, `busy` low the next cycle. A `start` pulsed during that busy period is ignored.
- `clear` during SHIFT with `bits_left` = 5 -> next cycle IDLE, `busy` 0, all outputs 0, `bits_left` 0. A fresh `start` then runs normally.
